// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcodes,
// datapath mux selects, ALU operation classes and trap causes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE_R, EXECUTE_I,
    MDU_EXEC, ALU_WB, JAL, JALR, BRANCH, LUI, AUIPC, TRAP
  } state_e;

  // Major opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] FUNCT7_MDU = 7'b0000001;

  // ALU A/B operand selects
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // Result bus select
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // Immediate formats
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Trap causes
  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // Operation class handed to the ALU decoder
  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT, ALUOP_MDU} alu_op_e;

  // ALUControl codes; the MDU reads funct3 itself, so its class is one code
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;
  localparam logic [3:0] ALU_MDU  = 4'd15;

  // Branch condition from funct3 and the ALU compare flags (010/011 reserved)
  function automatic logic branch_taken(input logic [2:0] f3, input logic zero,
                                        input logic lt, input logic ltu);
    case (f3)
      3'b000:  return zero;
      3'b001:  return !zero;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return ltu;
      3'b111:  return !ltu;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/aludecoder.sv
// ALU operation decoder: maps operation class plus funct fields to ALUControl.
module aludecoder
  import ctrl_pkg::*;
(
  input  alu_op_e    alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op_b5,
  output logic [3:0] alu_control
);

  // Select the ALU function; sub only for R-type, sra for either shift form
  always_comb begin
    // NOTE: default first so every path assigns the output and no latch forms.
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_MDU: alu_control = ALU_MDU;
      default: begin
        case (funct3)
          3'b000:  alu_control = (op_b5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b010:  alu_control = ALU_SLT;
          3'b011:  alu_control = ALU_SLTU;
          3'b100:  alu_control = ALU_XOR;
          3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  alu_control = ALU_OR;
          default: alu_control = ALU_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle RISC-V control FSM with memory/MDU handshakes, wait timeout and
// illegal-instruction trap.
module mc_control_unit
  import ctrl_pkg::*;
#(
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter bit          MDU_EN        = 1'b1,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       Zero,
  input  logic       Lt,
  input  logic       Ltu,
  input  logic       MemReady,
  input  logic       MdDone,
  output logic [2:0] ImmSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic [3:0] ALUControl,
  output logic [2:0] LST,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       MemReq,
  output logic       LSE,
  output logic       MdStart,
  output logic       Trap,
  output logic [1:0] TrapCause
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  state_e           state, next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       trap_cause_q, trap_next;
  logic             md_wb_q;
  logic             mem_ready, waiting, done, timeout_hit;
  logic [2:0]       imm_sel;
  alu_op_e          alu_op;

  assign mem_ready = MEM_HANDSHAKE ? MemReady : 1'b1;

  // State, wait counter, latched trap cause and "came from MDU" flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= FETCH;
      wait_cnt     <= '0;
      trap_cause_q <= CAUSE_NONE;
      md_wb_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values together.
      state   <= next_state;
      md_wb_q <= (state == MDU_EXEC);
      if (next_state != state) wait_cnt <= '0;
      else if (waiting)        wait_cnt <= wait_cnt + 1'b1;
      if (state != TRAP && next_state == TRAP) trap_cause_q <= trap_next;
    end
  end

  // Wait-state detection; completion on the last allowed cycle beats timeout
  always_comb begin
    waiting = 1'b0;
    done    = 1'b0;
    case (state)
      FETCH, MEM_READ, MEM_WRITE: begin waiting = 1'b1; done = mem_ready; end
      MDU_EXEC:                   begin waiting = 1'b1; done = MdDone;    end
      default: ;
    endcase
    timeout_hit = waiting && !done && (wait_cnt == CNT_W'(TIMEOUT - 1));
  end

  // Immediate format from opcode
  always_comb begin
    case (op)
      OP_STORE:         imm_sel = IMM_S;
      OP_BRANCH:        imm_sel = IMM_B;
      OP_JAL:           imm_sel = IMM_J;
      OP_LUI, OP_AUIPC: imm_sel = IMM_U;
      default:          imm_sel = IMM_I;
    endcase
  end

  // Next state and per-state control outputs
  always_comb begin
    next_state = state;
    trap_next  = CAUSE_NONE;
    alu_op     = ALUOP_ADD;
    ImmSrc     = IMM_I;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    ResultSrc  = RES_ALUOUT;
    AdrSrc     = 1'b0;
    LST        = 3'b000;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    MemReq     = 1'b0;
    LSE        = 1'b0;
    MdStart    = 1'b0;
    Trap       = 1'b0;
    TrapCause  = CAUSE_NONE;
    case (state)
      FETCH: begin
        MemReq    = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        if (mem_ready) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          next_state = DECODE;
        end
      end
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ImmSrc  = imm_sel;
        case (op)
          OP_LOAD, OP_STORE: next_state = MEM_ADR;
          OP_REG: begin
            if (funct7 != FUNCT7_MDU) next_state = EXECUTE_R;
            else if (MDU_EN)          next_state = MDU_EXEC;
            else begin next_state = TRAP; trap_next = CAUSE_ILLEGAL; end
          end
          OP_IMM:    next_state = EXECUTE_I;
          OP_BRANCH: next_state = BRANCH;
          OP_JAL:    next_state = JAL;
          OP_JALR:   next_state = JALR;
          OP_LUI:    next_state = LUI;
          OP_AUIPC:  next_state = AUIPC;
          default: begin next_state = TRAP; trap_next = CAUSE_ILLEGAL; end
        endcase
      end
      MEM_ADR: begin
        LSE        = 1'b1;
        LST        = funct3;
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        ImmSrc     = imm_sel;
        next_state = (op == OP_STORE) ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
        if (mem_ready) next_state = MEM_WB;
      end
      MEM_WB: begin
        ResultSrc  = RES_DATA;
        RegWrite   = 1'b1;
        next_state = FETCH;
      end
      MEM_WRITE: begin
        MemReq   = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (mem_ready) next_state = FETCH;
      end
      EXECUTE_R: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        alu_op     = ALUOP_FUNCT;
        next_state = ALU_WB;
      end
      EXECUTE_I: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        ImmSrc     = imm_sel;
        alu_op     = ALUOP_FUNCT;
        next_state = ALU_WB;
      end
      MDU_EXEC: begin
        alu_op  = ALUOP_MDU;
        // counter is cleared on entry, so zero marks the first cycle here
        MdStart = (wait_cnt == '0);
        if (MdDone) next_state = ALU_WB;
      end
      ALU_WB: begin
        ResultSrc  = md_wb_q ? RES_ALURESULT : RES_ALUOUT;
        RegWrite   = 1'b1;
        next_state = FETCH;
      end
      JAL: begin
        PCWrite    = 1'b1;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        next_state = ALU_WB;
      end
      JALR: begin
        PCWrite    = 1'b1;
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        ImmSrc     = imm_sel;
        ResultSrc  = RES_ALURESULT;
        next_state = ALU_WB;
      end
      BRANCH: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_RS2;
        alu_op     = ALUOP_SUB;
        ResultSrc  = RES_ALUOUT;
        PCWrite    = branch_taken(funct3, Zero, Lt, Ltu);
        next_state = FETCH;
      end
      LUI: begin
        ALUSrcA    = SRCA_ZERO;
        ALUSrcB    = SRCB_IMM;
        ImmSrc     = imm_sel;
        next_state = ALU_WB;
      end
      AUIPC: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_IMM;
        ImmSrc     = imm_sel;
        next_state = ALU_WB;
      end
      default: begin
        Trap      = 1'b1;
        TrapCause = trap_cause_q;
      end
    endcase
    if (timeout_hit) begin
      next_state = TRAP;
      trap_next  = CAUSE_TIMEOUT;
    end
    // reset is asynchronous, so strobes are gated directly rather than by state
    if (reset) begin
      IRWrite  = 1'b0;
      PCWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      MdStart  = 1'b0;
      Trap     = 1'b0;
    end
  end

  aludecoder u_aludecoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7[5]),
    .op_b5       (op[5]),
    .alu_control (ALUControl)
  );

endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 SHALL have parameter MEM_HANDSHAKE, default 1; 1 = honour MemReady, 0 = MemReady treated as constant 1.
REQ-002 SHALL have parameter MDU_EN, default 1; 1 = decode funct7=0000001 R-type as multiply/divide, 0 = such ops are illegal.
REQ-003 SHALL have parameter TIMEOUT, default 255; maximum wait cycles on MemReady/MdDone before bus-error trap.
REQ-004 SHALL have ports: clk in 1 system clock; reset in 1 async active-high reset.
REQ-005 SHALL have ports: op in 7 opcode; funct3 in 3; funct7 in 7; Zero, Lt, Ltu in 1 each, ALU compare flags.
REQ-006 SHALL have ports: MemReady in 1 memory completion; MdDone in 1 MDU result valid.
REQ-007 SHALL have ports: ImmSrc out 3 (I,S,B,J,U); ALUSrcA out 2 (00 PC, 01 OldPC, 10 rs1, 11 zero); ALUSrcB out 2 (00 rs2, 01 imm, 10 const 4).
REQ-008 SHALL have ports: ResultSrc out 2 (00 ALUOut, 01 Data, 10 ALUResult); AdrSrc out 1; ALUControl out 4; LST out 3.
REQ-009 SHALL have ports: IRWrite, PCWrite, RegWrite, MemWrite, MemReq, LSE, MdStart out 1 each; Trap out 1; TrapCause out 2 (01 illegal, 10 bus timeout).

Function
REQ-010 SHALL implement states FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE_R, EXECUTE_I, MDU_EXEC, ALU_WB, JAL, JALR, BRANCH, LUI, AUIPC, TRAP.
REQ-011 SHALL decode all outputs combinationally from state plus inputs; unlisted outputs are 0 in every state.
REQ-012 FETCH SHALL assert MemReq, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10; IRWrite and PCUpdate only in the cycle MemReady=1; stay in FETCH until then.
REQ-013 DECODE SHALL compute OldPC+imm (ALUSrcA=01, ALUSrcB=01) and branch to the state matching op; unknown op, or MDU op with MDU_EN=0, SHALL go to TRAP with TrapCause=01.
REQ-014 MEM_ADR SHALL drive LSE=1, LST=funct3, rs1+imm; go to MEM_READ for load, MEM_WRITE for store.
REQ-015 MEM_READ SHALL assert MemReq, AdrSrc=1, advance to MEM_WB on MemReady; MEM_WRITE SHALL hold MemReq, MemWrite, AdrSrc=1 until MemReady, then go to FETCH.
REQ-016 MDU_EXEC SHALL pulse MdStart for exactly its first cycle and wait for MdDone, then go to ALU_WB with ResultSrc=10 in that ALU_WB cycle.
REQ-017 LUI SHALL compute zero+imm (ALUSrcA=11); AUIPC SHALL compute OldPC+imm; both go to ALU_WB.
REQ-018 JAL SHALL write PC=ALUOut (OldPC+imm), compute OldPC+4 and go to ALU_WB; JALR SHALL load PC from rs1+imm and go to ALU_WB.
REQ-019 BRANCH SHALL assert PCWrite when taken: beq Zero, bne !Zero, blt Lt, bge !Lt, bltu Ltu, bgeu !Ltu; funct3 010/011 SHALL never be taken; then FETCH.
REQ-020 ALU_WB and MEM_WB SHALL assert RegWrite for exactly one cycle and go to FETCH.
REQ-021 A wait counter SHALL clear on every state change and count each cycle spent waiting in FETCH, MEM_READ, MEM_WRITE or MDU_EXEC; when it reaches TIMEOUT without completion, next state SHALL be TRAP with TrapCause=10.
REQ-022 TRAP SHALL hold Trap=1 and TrapCause, suppress all write enables, and remain until reset.
REQ-023 Completion arriving in the same cycle as the counter reaching TIMEOUT SHALL win; no trap.

Reset
REQ-024 Reset SHALL force state FETCH, wait counter 0, TrapCause 00 immediately and asynchronously, abandoning any access in progress.
REQ-025 During reset all write enables, MdStart and Trap SHALL be 0; after release only MemReq=1 and FETCH mux selects are active.

Structure
REQ-026 State enum, opcode constants, ALUSrcA/B, ResultSrc and TrapCause encodings SHALL live in shared package ctrl_pkg.
REQ-027 ALU operation decode SHALL be the existing aludecoder sub-module, extended with an MDU op class; immediate-select decode stays inline.

Verification
REQ-028 add x1,x2,x3 with MemReady=1 -> FETCH,DECODE,EXECUTE_R,ALU_WB; RegWrite in cycle 4 only.
REQ-029 lw with MemReady low 3 cycles in MEM_READ -> MEM_WB entered 4 cycles after MEM_READ entry; one RegWrite.
REQ-030 bge with Lt=0 -> PCWrite=1 in BRANCH; with Lt=1 -> PCWrite=0.
REQ-031 TIMEOUT=4, MemReady held 0 in FETCH -> TRAP after 4 wait cycles, TrapCause=10, no IRWrite.
REQ-032 op=7'h7F -> TRAP, TrapCause=01; reset asserted mid-MEM_WRITE -> MemWrite drops at once, FETCH on release.
